mem_1r1w_masked_fifo: RTL and testbench
=======================================

# mem_1r1w_masked_fifo

Single-clock 64-bit streaming FIFO controller that owns the port side of the `mem_1r1w_masked` storage macro (32 x 64, 8-bit mask granule). It accepts words from an upstream valid/ready producer, writes them through the W0 port, prefetches them through the R0 port, and presents them to a downstream valid/ready consumer. A 2-entry output buffer hides the 1-cycle macro read latency so that sustained throughput is one word per cycle.

## Interface
Parameters:
- DEPTH, 32, macro entries; power of two; address width AW = log2(DEPTH) = 5.
- WIDTH, 64, data width in bits.
- MASK_GRAN, 8, bits per mask lane; mask width MW = WIDTH/MASK_GRAN = 8.

Ports:
- clock  in  1  single clock for all logic; also drives R0_clk and W0_clk externally.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all occupancy; data in the macro is not erased.
- enq_valid  in  1  upstream word valid.
- enq_ready  out  1  upstream may transfer.
- enq_bits  in  WIDTH  upstream word.
- deq_valid  out  1  downstream word valid.
- deq_ready  in  1  downstream accepts.
- deq_bits  out  WIDTH  downstream word.
- count  out  6  total words held: macro plus in-flight plus output buffer, 0..DEPTH+2.
- W0_addr  out  AW  macro write address.
- W0_en  out  1  macro write strobe, active-high.
- W0_data  out  WIDTH  macro write data.
- W0_mask  out  MW  macro byte mask.
- R0_addr  out  AW  macro read address.
- R0_en  out  1  macro read strobe, active-high.
- R0_data  in  WIDTH  macro read data, valid the cycle after R0_en.

## Operation
- State registers:
  - wr_ptr and rd_ptr, AW+1 bits each, with the MSB used as the wrap bit.
  - inflight, 1 bit: a read was issued last cycle.
  - obuf, 2 x WIDTH, kept in order with obuf_cnt 0..2.
- mem_cnt = wr_ptr - rd_ptr (modulo 2^(AW+1)), range 0..DEPTH.
- enq_ready = (mem_cnt != DEPTH).
  - It is a function of registers only; it never depends combinationally on deq_ready.
- Enqueue fire (enq_valid & enq_ready):
  - W0_en = 1, W0_addr = wr_ptr[AW-1:0], W0_data = enq_bits, W0_mask = all ones.
  - wr_ptr increments.
  - When not firing: W0_en = 0 and W0_mask = 0; W0_data still equals enq_bits.
- Deq fire (deq_valid & deq_ready): pops the obuf head.
- deq_valid = (obuf_cnt != 0), and deq_bits = obuf head.
  - deq_bits is held stable while deq_valid is high and deq_ready is low.
- Read issue: R0_en = (mem_cnt != 0) & (obuf_cnt + inflight - deq_fire < 2).
  - On issue, R0_addr = rd_ptr[AW-1:0] and rd_ptr increments.
  - When not issuing, R0_addr holds its last value.
- Read return: when inflight = 1, R0_data is written into obuf at slot obuf_cnt - deq_fire.
  - The guard on R0_en guarantees this slot never overflows.
- Read and write never target the same address in one cycle.
  - The write slot is always empty; the read slot is always occupied.
- count = mem_cnt + inflight + obuf_cnt.
- Pointer wrap: address 31 is followed by address 0 and the wrap bit toggles.
  - Full and empty are distinguished by the wrap bit.
- Simultaneous enq and deq at mem_cnt = DEPTH: the enq is refused that cycle.
- Simultaneous enq and read issue at mem_cnt = 0: no read is issued.
  - The write becomes readable in the next cycle; there is no write-to-read bypass.
- flush, and reset likewise:
  - Clears wr_ptr, rd_ptr, inflight and obuf_cnt.
  - Any R0_data returning in the next cycle is discarded.
  - During a flush cycle, enq_valid and deq_ready are ignored: no W0_en, no R0_en, no fire.
- Reset mid-operation behaves identically to flush, and additionally clears obuf contents to 0.

## Timing
- Reset values:
  - enq_ready = 1, deq_valid = 0, deq_bits = 0, count = 0.
  - W0_en = 0, W0_mask = 0, W0_addr = 0.
  - R0_en = 0, R0_addr = 0.
- Empty-to-output latency: an enqueue fire in cycle T gives R0_en in T+1, capture in T+2, deq_valid in T+3.
- Sustained throughput is 1 word/cycle with enq_valid = deq_ready = 1 continuously, after the 3-cycle fill.
- Backpressure: with deq_ready = 0, the FIFO accepts exactly DEPTH+2 = 34 words.
  - The first two words prefetch into obuf; enq_ready falls after mem_cnt reaches 32.
- enq_ready rises the cycle after the read issue that drops mem_cnt below DEPTH.

## Test plan
- Reset, then idle: all outputs hold their reset values; count = 0; no R0_en or W0_en for 10 cycles.
- Single word 0x0123_4567_89AB_CDEF enqueued in cycle T:
  - W0_en = 1, W0_addr = 0, W0_mask = 0xFF in T.
  - R0_en = 1, R0_addr = 0 in T+1.
  - deq_valid = 1 with deq_bits = 0x0123_4567_89AB_CDEF in T+3.
- Fill with deq_ready = 0, pushing data = index 0..40:
  - 34 words are accepted and enq_ready = 0 afterwards; count = 34.
  - Draining returns 0..33 in order; count then falls to 0.
- Streaming 100 words with enq_valid = deq_ready = 1:
  - After fill, one deq fire per cycle.
  - Addresses wrap 31 to 0 three times.
  - Output equals the input sequence.
- Random deq_ready (50%) against a scoreboard for 1000 words: no loss or reorder, deq_bits stable while stalled.
- flush asserted with count = 20 while a read is in flight:
  - The next cycle shows count = 0, deq_valid = 0, enq_ready = 1.
  - The stale R0_data is not delivered.
  - A following enqueue of 0xAA is delivered after 3 cycles.

Source files
------------

// File: rtl/mem_1r1w_masked_fifo.sv
// Streaming 64-bit FIFO controller driving the W0/R0 ports of the mem_1r1w_masked macro.
// A two-entry output buffer absorbs the one-cycle macro read latency for full throughput.
module mem_1r1w_masked_fifo #(
   parameter  int DEPTH     = 32,
   parameter  int WIDTH     = 64,
   parameter  int MASK_GRAN = 8,
   localparam int AW        = $clog2(DEPTH),
   localparam int MW        = WIDTH / MASK_GRAN
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_bits,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_bits,
   output logic [5:0]       count,
   output logic [AW-1:0]    W0_addr,
   output logic             W0_en,
   output logic [WIDTH-1:0] W0_data,
   output logic [MW-1:0]    W0_mask,
   output logic [AW-1:0]    R0_addr,
   output logic             R0_en,
   input  logic [WIDTH-1:0] R0_data
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             r_inflight;
   logic [WIDTH-1:0] r_obuf0;
   logic [WIDTH-1:0] r_obuf1;
   logic [1:0]       r_obuf_cnt;
   logic [AW-1:0]    r_r0_addr;

   logic [AW:0]      w_mem_cnt;
   logic             w_block;
   logic             w_enq_fire;
   logic             w_deq_fire;
   logic [2:0]       w_slots;
   logic             w_rd_issue;
   logic [1:0]       w_cnt_pop;
   logic [1:0]       w_obuf_cnt_nxt;
   logic [WIDTH-1:0] w_obuf0_nxt;
   logic [WIDTH-1:0] w_obuf1_nxt;

   // Handshakes are suppressed entirely during reset or flush cycles.
   assign w_mem_cnt  = r_wr_ptr - r_rd_ptr;
   assign w_block    = reset | flush;
   assign enq_ready  = (w_mem_cnt != FULL_CNT);
   assign deq_valid  = (r_obuf_cnt != 2'd0);
   assign deq_bits   = r_obuf0;
   assign w_enq_fire = enq_valid & enq_ready & ~w_block;
   assign w_deq_fire = deq_valid & deq_ready & ~w_block;

   // Only issue a read if the buffer can take it after this cycle's pop.
   assign w_slots    = {1'b0, r_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_deq_fire};
   assign w_rd_issue = (w_mem_cnt != '0) & (w_slots < 3'd2) & ~w_block;

   assign W0_en   = w_enq_fire;
   assign W0_addr = r_wr_ptr[AW-1:0];
   assign W0_data = enq_bits;
   assign W0_mask = {MW{w_enq_fire}};
   assign R0_en   = w_rd_issue;
   assign R0_addr = w_rd_issue ? r_rd_ptr[AW-1:0] : r_r0_addr;
   assign count   = 6'(w_mem_cnt) + 6'(r_inflight) + 6'(r_obuf_cnt);

   // Output buffer next state: pop the head, then land returning read data behind survivors.
   always_comb begin
      w_obuf1_nxt = r_obuf1;
      w_cnt_pop   = r_obuf_cnt - {1'b0, w_deq_fire};
      if (w_deq_fire) begin
         w_obuf0_nxt = r_obuf1;
      end else begin
         w_obuf0_nxt = r_obuf0;
      end
      if (r_inflight) begin
         if (w_cnt_pop == 2'd0) begin
            w_obuf0_nxt = R0_data;
         end else begin
            w_obuf1_nxt = R0_data;
         end
         w_obuf_cnt_nxt = w_cnt_pop + 2'd1;
      end else begin
         w_obuf_cnt_nxt = w_cnt_pop;
      end
   end

   // Pointer, in-flight and output buffer state; flush keeps buffer contents and R0_addr.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= 1'b0;
         r_obuf0    <= '0;
         r_obuf1    <= '0;
         r_obuf_cnt <= 2'd0;
         r_r0_addr  <= '0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= 1'b0;
         r_obuf_cnt <= 2'd0;
      end else begin
         if (w_enq_fire) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_issue) begin
            r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            r_r0_addr <= r_rd_ptr[AW-1:0];
         end
         r_inflight <= w_rd_issue;
         r_obuf0    <= w_obuf0_nxt;
         r_obuf1    <= w_obuf1_nxt;
         r_obuf_cnt <= w_obuf_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_mem_1r1w_masked_fifo.sv
// Self-checking bench for mem_1r1w_masked_fifo with a behavioural macro and queue scoreboard.
module tb_mem_1r1w_masked_fifo;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        enq_valid = 1'b0;
   logic        enq_ready;
   logic [63:0] enq_bits = 64'h0;
   logic        deq_valid;
   logic        deq_ready = 1'b0;
   logic [63:0] deq_bits;
   logic [5:0]  count;
   logic [4:0]  W0_addr;
   logic        W0_en;
   logic [63:0] W0_data;
   logic [7:0]  W0_mask;
   logic [4:0]  R0_addr;
   logic        R0_en;
   logic [63:0] R0_data;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [63:0] mem [32];

   always #5 clock = ~clock;

   mem_1r1w_masked_fifo dut (
      .clock(clock), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
      .count(count),
      .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
      .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
   );

   // Behavioural 32x64 macro with byte mask and one-cycle read latency.
   always @(posedge clock) begin
      if (W0_en) begin
         for (int b = 0; b < 8; b++) begin
            if (W0_mask[b]) mem[W0_addr][b*8 +: 8] <= W0_data[b*8 +: 8];
         end
      end
      if (R0_en) R0_data <= mem[R0_addr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic ev, input logic [63:0] eb, input logic dr, input logic fl);
      @(negedge clock);
      enq_valid = ev;
      enq_bits  = eb;
      deq_ready = dr;
      flush     = fl;
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [91:0] obs;
      logic [91:0] exp_v;
      reset = 1'b1;
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      vec_cnt++;
      if ({W0_en, R0_en} !== 2'b00) begin
         err_cnt++; $display("FAIL reset_strobes: got %b expected 00", {W0_en, R0_en});
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      reset = 1'b0;
      exp_v = {1'b1, 1'b0, 64'h0, 6'd0, 1'b0, 8'h00, 5'd0, 1'b0, 5'd0};
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 64'h0, 1'b0, 1'b0);
         obs = {enq_ready, deq_valid, deq_bits, count, W0_en, W0_mask, W0_addr, R0_en, R0_addr};
         vec_cnt++;
         if (obs !== exp_v) begin
            err_cnt++; $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_single();
      logic [63:0] w;
      w = 64'h0123_4567_89AB_CDEF;
      apply_reset();
      drive(1'b1, w, 1'b0, 1'b0);
      vec_cnt++;
      if ({W0_en, W0_addr, W0_mask, W0_data} !== {1'b1, 5'd0, 8'hFF, w}) begin
         err_cnt++; $display("FAIL single_write: got %b/%0d/%h/%h expected 1/0/ff/%h", W0_en, W0_addr, W0_mask, W0_data, w);
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if ({R0_en, R0_addr, W0_en, W0_mask} !== {1'b1, 5'd0, 1'b0, 8'h00}) begin
         err_cnt++; $display("FAIL single_read: got R0_en %b R0_addr %0d W0_en %b W0_mask %h expected 1 0 0 00", R0_en, R0_addr, W0_en, W0_mask);
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if (deq_valid !== 1'b0) begin
         err_cnt++; $display("FAIL single_early: got deq_valid %b expected 0", deq_valid);
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if ({deq_valid, deq_bits, count} !== {1'b1, w, 6'd1}) begin
         err_cnt++; $display("FAIL single_out: got %b %h cnt %0d expected 1 %h cnt 1", deq_valid, deq_bits, count, w);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if ({deq_valid, count} !== {1'b0, 6'd0}) begin
         err_cnt++; $display("FAIL single_drain: got %b cnt %0d expected 0 cnt 0", deq_valid, count);
      end
   endtask

   task automatic test_fill();
      int acc;
      int got;
      acc = 0;
      got = 0;
      apply_reset();
      for (int i = 0; i <= 40; i++) begin
         drive(1'b1, 64'(i), 1'b0, 1'b0);
         if (enq_ready) begin
            vec_cnt++;
            if (W0_addr !== 5'(acc)) begin
               err_cnt++; $display("FAIL fill_waddr: got %0d expected %0d", W0_addr, acc % 32);
            end
            acc++;
         end
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if (acc !== 34 || enq_ready !== 1'b0 || count !== 6'd34) begin
         err_cnt++; $display("FAIL fill_full: got acc %0d rdy %b cnt %0d expected 34 0 34", acc, enq_ready, count);
      end
      for (int c = 0; c < 200 && got < 34; c++) begin
         drive(1'b0, 64'h0, 1'b1, 1'b0);
         if (deq_valid) begin
            vec_cnt++;
            if (deq_bits !== 64'(got)) begin
               err_cnt++; $display("FAIL fill_order: got %0d expected %0d", deq_bits, got);
            end
            got++;
         end
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if (got !== 34 || count !== 6'd0 || deq_valid !== 1'b0) begin
         err_cnt++; $display("FAIL fill_drain: got n %0d cnt %0d vld %b expected 34 0 0", got, count, deq_valid);
      end
   endtask

   task automatic test_stream();
      logic [63:0] in_w [100];
      int sent, got, rd, first, last, wraps;
      sent = 0; got = 0; rd = 0; first = -1; last = -1; wraps = 0;
      for (int i = 0; i < 100; i++) in_w[i] = {$urandom, $urandom};
      apply_reset();
      for (int c = 0; c < 400 && got < 100; c++) begin
         drive(sent < 100, (sent < 100) ? in_w[sent] : 64'h0, 1'b1, 1'b0);
         if (sent < 100 && enq_ready) begin
            vec_cnt++;
            if (W0_addr !== 5'(sent) || W0_en !== 1'b1) begin
               err_cnt++; $display("FAIL stream_waddr: got %0d en %b expected %0d en 1", W0_addr, W0_en, sent % 32);
            end
            if (sent > 0 && W0_addr == 5'd0) wraps++;
            sent++;
         end
         if (R0_en) begin
            vec_cnt++;
            if (R0_addr !== 5'(rd)) begin
               err_cnt++; $display("FAIL stream_raddr: got %0d expected %0d", R0_addr, rd % 32);
            end
            rd++;
         end
         if (deq_valid) begin
            vec_cnt++;
            if (deq_bits !== in_w[got]) begin
               err_cnt++; $display("FAIL stream_data[%0d]: got %h expected %h", got, deq_bits, in_w[got]);
            end
            if (first < 0) first = c;
            last = c;
            got++;
         end
      end
      vec_cnt++;
      if (got !== 100 || first !== 3 || last - first !== 99 || wraps !== 3) begin
         err_cnt++; $display("FAIL stream_rate: got n %0d first %0d span %0d wraps %0d expected 100 3 99 3", got, first, last - first, wraps);
      end
   endtask

   task automatic test_random();
      logic [63:0] sb [$];
      logic [63:0] d;
      logic [63:0] exp_w;
      logic [63:0] prev_bits;
      logic        ev, dr, prev_stall;
      int sent, got, mc;
      sent = 0; got = 0; mc = 0; prev_stall = 1'b0; prev_bits = 64'h0;
      apply_reset();
      for (int c = 0; c < 20000 && got < 1000; c++) begin
         ev = (sent < 1000) && ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 1) == 1);
         d  = {$urandom, $urandom};
         drive(ev, d, dr, 1'b0);
         vec_cnt++;
         if (count !== 6'(mc)) begin
            err_cnt++; $display("FAIL rand_count: got %0d expected %0d", count, mc);
         end
         if (mc < 32 && enq_ready !== 1'b1) begin
            vec_cnt++; err_cnt++; $display("FAIL rand_ready: got %b expected 1 at %0d held", enq_ready, mc);
         end
         if (prev_stall) begin
            vec_cnt++;
            if (deq_valid !== 1'b1 || deq_bits !== prev_bits) begin
               err_cnt++; $display("FAIL rand_stable: got %b %h expected 1 %h", deq_valid, deq_bits, prev_bits);
            end
         end
         vec_cnt++;
         if (W0_mask !== ((ev && enq_ready) ? 8'hFF : 8'h00)) begin
            err_cnt++; $display("FAIL rand_mask: got %h expected %h", W0_mask, (ev && enq_ready) ? 8'hFF : 8'h00);
         end
         if (ev && enq_ready) begin
            sb.push_back(d);
            mc++;
            sent++;
         end
         if (deq_valid && dr) begin
            vec_cnt++;
            if (sb.size() == 0) begin
               err_cnt++; $display("FAIL rand_extra: got %h expected nothing", deq_bits);
            end else begin
               exp_w = sb.pop_front();
               if (deq_bits !== exp_w) begin
                  err_cnt++; $display("FAIL rand_data[%0d]: got %h expected %h", got, deq_bits, exp_w);
               end
            end
            mc--;
            got++;
         end
         prev_stall = deq_valid && !dr;
         prev_bits  = deq_bits;
      end
      vec_cnt++;
      if (got !== 1000 || sb.size() !== 0) begin
         err_cnt++; $display("FAIL rand_total: got %0d left %0d expected 1000 0", got, sb.size());
      end
   endtask

   task automatic test_flush();
      logic rd_prev;
      apply_reset();
      for (int i = 0; i < 22; i++) drive(1'b1, 64'(100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 64'h0, 1'b1, 1'b0);
         vec_cnt++;
         if (deq_valid !== 1'b1 || deq_bits !== 64'(100 + i)) begin
            err_cnt++; $display("FAIL flush_pre_pop: got %b %0d expected 1 %0d", deq_valid, deq_bits, 100 + i);
         end
      end
      rd_prev = R0_en;
      drive(1'b1, 64'h55, 1'b1, 1'b1);
      vec_cnt++;
      if ({rd_prev, count, W0_en, R0_en} !== {1'b1, 6'd20, 1'b0, 1'b0}) begin
         err_cnt++; $display("FAIL flush_cycle: got inflight %b cnt %0d W0 %b R0 %b expected 1 20 0 0", rd_prev, count, W0_en, R0_en);
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if ({count, deq_valid, enq_ready} !== {6'd0, 1'b0, 1'b1}) begin
         err_cnt++; $display("FAIL flush_after: got cnt %0d vld %b rdy %b expected 0 0 1", count, deq_valid, enq_ready);
      end
      drive(1'b1, 64'hAA, 1'b0, 1'b0);
      for (int i = 1; i <= 2; i++) begin
         drive(1'b0, 64'h0, 1'b0, 1'b0);
         vec_cnt++;
         if (deq_valid !== 1'b0) begin
            err_cnt++; $display("FAIL flush_stale[%0d]: got vld %b data %h expected 0", i, deq_valid, deq_bits);
         end
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      vec_cnt++;
      if ({deq_valid, deq_bits, count} !== {1'b1, 64'hAA, 6'd1}) begin
         err_cnt++; $display("FAIL flush_refill: got %b %h cnt %0d expected 1 aa cnt 1", deq_valid, deq_bits, count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_random();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
